// File: rtl/ifetch_icache.sv
// rtl/ifetch_icache.sv - instruction fetch stage with a direct-mapped one-word-per-line instruction cache
module ifetch_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int IC_INDEX_BITS = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_mem_instr_done,
    input  logic [31:0]           in_mem_instr,
    output logic                  out_mem_get_instr,
    output logic [ADDR_WIDTH-1:0] out_mem_address,
    input  logic                  in_iq_full,
    output logic                  out_iq_valid,
    output logic [31:0]           out_iq_instr,
    output logic [ADDR_WIDTH-1:0] out_iq_pc,
    input  logic                  in_misbranch,
    input  logic [ADDR_WIDTH-1:0] in_jump_pc
);
    localparam int ENTRIES = 1 << IC_INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - IC_INDEX_BITS - 2;

    typedef enum logic {
        FETCH    = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   pc, pc_n;
    logic [ENTRIES-1:0]      valid;
    logic [31:0]             data [ENTRIES];
    logic [TAG_W-1:0]        tags [ENTRIES];

    logic                    get_n, iq_valid_n, fill_en, hit;
    logic [ADDR_WIDTH-1:0]   addr_n, iq_pc_n;
    logic [31:0]             iq_instr_n;
    logic [IC_INDEX_BITS-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, fill_tag;

    assign pc_idx   = pc[IC_INDEX_BITS+1:2];
    assign pc_tag   = pc[ADDR_WIDTH-1:IC_INDEX_BITS+2];
    assign fill_idx = out_mem_address[IC_INDEX_BITS+1:2];
    assign fill_tag = out_mem_address[ADDR_WIDTH-1:IC_INDEX_BITS+2];
    assign hit      = valid[pc_idx] && (tags[pc_idx] == pc_tag);

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        get_n      = 1'b0;
        addr_n     = out_mem_address;
        iq_valid_n = 1'b0;
        iq_instr_n = out_iq_instr;
        iq_pc_n    = out_iq_pc;
        fill_en    = 1'b0;
        if (in_misbranch) begin
            // A word landing with the redirect is still correct for its address, so keep it.
            pc_n    = in_jump_pc;
            state_n = FETCH;
            fill_en = (state == WAIT_MEM) && in_mem_instr_done;
        end else begin
            case (state)
                FETCH: begin
                    if (!in_iq_full) begin
                        if (hit) begin
                            iq_valid_n = 1'b1;
                            iq_instr_n = data[pc_idx];
                            iq_pc_n    = pc;
                            pc_n       = pc + ADDR_WIDTH'(4);
                        end else begin
                            get_n   = 1'b1;
                            addr_n  = pc;
                            state_n = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (in_mem_instr_done) begin
                        fill_en = 1'b1;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            valid             <= '0;
            out_mem_get_instr <= 1'b0;
            out_mem_address   <= '0;
            out_iq_valid      <= 1'b0;
            out_iq_instr      <= '0;
            out_iq_pc         <= '0;
        end else if (rdy) begin
            state             <= state_n;
            pc                <= pc_n;
            out_mem_get_instr <= get_n;
            out_mem_address   <= addr_n;
            out_iq_valid      <= iq_valid_n;
            out_iq_instr      <= iq_instr_n;
            out_iq_pc         <= iq_pc_n;
            if (fill_en) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Line payload needs no reset; the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            data[fill_idx] <= in_mem_instr;
            tags[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: doc/ifetch_icache.md
Name: ifetch_icache

Overview:
- Instruction fetch stage sitting directly upstream of the memory controller.
- Holds the PC and a direct-mapped instruction cache.
- On a hit, pushes {instr, pc} into the instruction queue, one per cycle.
- On a miss, issues a one-cycle fetch request to the memory controller, waits for the 32-bit word, fills the cache, then resumes.
- A misbranch redirect from the ROB replaces the PC and abandons any outstanding miss.

Parameters:
- ADDR_WIDTH, 32: PC/address width.
- IC_INDEX_BITS, 6: log2 of cache entries (64 entries, one 32-bit word each).
- RESET_PC, 0: PC value after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- rdy  input  1  global enable; when 0, all state holds.
- in_mem_instr_done  input  1  one-cycle pulse from memory controller: requested word is on in_mem_instr.
- in_mem_instr  input  32  fetched instruction word.
- out_mem_get_instr  output  1  one-cycle fetch request pulse.
- out_mem_address  output  ADDR_WIDTH  word address of the request; held stable until done or misbranch.
- in_iq_full  input  1  instruction queue cannot accept a push. The queue raises it with ≥1 slot still free, because one push may be in flight.
- out_iq_valid  output  1  push strobe, one cycle per instruction.
- out_iq_instr  output  32  instruction pushed.
- out_iq_pc  output  ADDR_WIDTH  PC of the pushed instruction.
- in_misbranch  input  1  flush/redirect request.
- in_jump_pc  input  ADDR_WIDTH  redirect target, valid with in_misbranch.

Behaviour:
- Reset (rst=1 at a posedge, overrides everything including rdy=0):
  - pc=RESET_PC, state=FETCH, all cache valid bits=0.
  - out_mem_get_instr=0, out_mem_address=0, out_iq_valid=0, out_iq_instr=0, out_iq_pc=0.
  - Reset mid-miss drops the miss; any later done pulse is ignored (state is FETCH).
- Address split:
  - index = pc[IC_INDEX_BITS+1:2].
  - tag = pc[ADDR_WIDTH-1:IC_INDEX_BITS+2].
  - pc[1:0] is always 0.
- All outputs are registered. out_iq_valid and out_mem_get_instr default to 0 every active cycle (pulses).
- rdy=0: no state or output change; pulses are not re-emitted.
- State FETCH, each posedge with rdy=1 and in_misbranch=0:
  - in_iq_full=1: stall, nothing changes.
  - Hit (valid[index] && tag match): out_iq_valid<=1, out_iq_instr<=data[index], out_iq_pc<=pc, pc<=pc+4. Back-to-back hits give one push per cycle.
  - Miss: out_mem_get_instr<=1 for exactly one cycle, out_mem_address<=pc, state<=WAIT_MEM.
- State WAIT_MEM:
  - Wait for in_mem_instr_done. No timeout.
  - On done: data[idx(out_mem_address)]<=in_mem_instr, tag and valid written, state<=FETCH.
  - No push in the done cycle. The next FETCH cycle hits, so miss-to-push latency = controller latency + 2 cycles.
  - in_iq_full is ignored in WAIT_MEM.
- Misbranch (rdy=1, in_misbranch=1), highest priority after reset:
  - pc<=in_jump_pc, state<=FETCH, out_iq_valid<=0, out_mem_get_instr<=0.
  - The memory controller drops its pending request on the same signal.
  - If in_mem_instr_done coincides with in_misbranch, the word is still written to the cache at out_mem_address (data is correct for that address) but not pushed.
  - Cache contents are never flushed by misbranch.
- PC wraps modulo 2^ADDR_WIDTH; no special handling.
- Write then read of the same index: the fill occurs in the done cycle; the lookup happens the following cycle and sees the new line.

Test Plan:
- Cold start: reset with RESET_PC=0; memory returns 0x00000013 after 5 cycles → one request pulse, out_mem_address=0; push {0x00000013, pc=0} 2 cycles after done; then request for pc=4.
- Warm loop: preload 0x0–0xC via misses, then misbranch to 0x0 → four consecutive-cycle pushes, pc 0,4,8,C, with no memory requests.
- Conflict: fill 0x000, then fetch 0x100 (same index, different tag) → miss, request at 0x100; later return to 0x000 misses again.
- Backpressure: in_iq_full=1 for 3 cycles during hits → no push and pc frozen; first push after deassert carries the held pc.
- Redirect mid-miss: misbranch to 0x40 while WAIT_MEM at 0x8 → next request is 0x40; a stale done pulse arriving with the misbranch fills 0x8 and produces no push.
- rdy=0 for 4 cycles mid-WAIT_MEM with a done pulse held → outputs frozen; fill and FETCH resume only when rdy=1.
